// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one instruction-fetch and one data requester share a
// single-outstanding memory port, with fetch starvation bounded by STARVE_LIMIT.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ireq,
  input  logic [31:0] i_iaddr,
  output logic        o_iready,
  output logic        o_irvalid,
  output logic [31:0] o_irdata,
  input  logic        i_dreq,
  input  logic [31:0] i_daddr,
  input  logic        i_dwen,
  input  logic [31:0] i_dwdata,
  input  logic [3:0]  i_dmask,
  output logic        o_dready,
  output logic        o_drvalid,
  output logic [31:0] o_drdata,
  output logic        o_mreq,
  output logic [31:0] o_maddr,
  output logic        o_mwen,
  output logic [31:0] o_mwdata,
  output logic [3:0]  o_mmask,
  input  logic        i_mready,
  input  logic        i_mrvalid,
  input  logic [31:0] i_mrdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic            sel_fetch_q, sel_fetch_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic            wen_q, wen_nxt;
  logic [DW-1:0]   wdata_q, wdata_nxt;
  logic [MW-1:0]   mask_q, mask_nxt;
  logic [CW-1:0]   starve_q, starve_nxt;
  logic [DW-1:0]   irdata_q, irdata_nxt;
  logic [DW-1:0]   drdata_q, drdata_nxt;
  logic            grant_fetch;

  // State and latched-transaction registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      sel_fetch_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      mask_q      <= '0;
      starve_q    <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
    end else begin
      state       <= state_nxt;
      sel_fetch_q <= sel_fetch_nxt;
      addr_q      <= addr_nxt;
      wen_q       <= wen_nxt;
      wdata_q     <= wdata_nxt;
      mask_q      <= mask_nxt;
      starve_q    <= starve_nxt;
      irdata_q    <= irdata_nxt;
      drdata_q    <= drdata_nxt;
    end
  end

  assign o_irdata = irdata_q;
  assign o_drdata = drdata_q;

  // Data wins unless fetch is alone or has waited through STARVE_LIMIT data grants
  assign grant_fetch = i_ireq && (!i_dreq || (starve_q == CW'(STARVE_LIMIT)));

  // Next-state and outputs
  always_comb begin
    state_nxt     = state;
    sel_fetch_nxt = sel_fetch_q;
    addr_nxt      = addr_q;
    wen_nxt       = wen_q;
    wdata_nxt     = wdata_q;
    mask_nxt      = mask_q;
    starve_nxt    = starve_q;
    irdata_nxt    = irdata_q;
    drdata_nxt    = drdata_q;
    o_iready      = 1'b0;
    o_dready      = 1'b0;
    o_irvalid     = 1'b0;
    o_drvalid     = 1'b0;
    o_mreq        = 1'b0;
    o_maddr       = '0;
    o_mwen        = 1'b0;
    o_mwdata      = '0;
    o_mmask       = '0;

    case (state)
      IDLE: begin
        if ((i_ireq || i_dreq) && !i_rst) begin
          state_nxt     = REQ;
          sel_fetch_nxt = grant_fetch;
          if (grant_fetch) begin
            o_iready   = 1'b1;
            addr_nxt   = i_iaddr;
            wen_nxt    = 1'b0;
            wdata_nxt  = '0;
            mask_nxt   = MW'(4'b1111);
            starve_nxt = '0;
          end else begin
            o_dready  = 1'b1;
            addr_nxt  = i_daddr;
            wen_nxt   = i_dwen;
            wdata_nxt = i_dwdata;
            mask_nxt  = i_dmask;
            if (i_ireq && (starve_q < CW'(STARVE_LIMIT)))
              starve_nxt = starve_q + CW'(1);
          end
        end
      end
      REQ: begin
        o_mreq   = 1'b1;
        o_maddr  = addr_q;
        o_mwen   = wen_q;
        o_mwdata = wdata_q;
        o_mmask  = mask_q;
        if (i_mready) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_mrvalid) begin
          if (sel_fetch_q) irdata_nxt = i_mrdata;
          else             drdata_nxt = i_mrdata;
          state_nxt = RESP;
        end
      end
      RESP: begin
        o_irvalid = sel_fetch_q;
        o_drvalid = !sel_fetch_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level arbitration and
// memory-timing model.
module tb_mem_arbiter;

  localparam int unsigned LIM = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ireq;
  logic [31:0] i_iaddr;
  logic        o_iready, o_irvalid;
  logic [31:0] o_irdata;
  logic        i_dreq;
  logic [31:0] i_daddr;
  logic        i_dwen;
  logic [31:0] i_dwdata;
  logic [3:0]  i_dmask;
  logic        o_dready, o_drvalid;
  logic [31:0] o_drdata;
  logic        o_mreq;
  logic [31:0] o_maddr;
  logic        o_mwen;
  logic [31:0] o_mwdata;
  logic [3:0]  o_mmask;
  logic        i_mready, i_mrvalid;
  logic [31:0] i_mrdata;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_iready(o_iready),
    .o_irvalid(o_irvalid), .o_irdata(o_irdata),
    .i_dreq(i_dreq), .i_daddr(i_daddr), .i_dwen(i_dwen), .i_dwdata(i_dwdata),
    .i_dmask(i_dmask), .o_dready(o_dready), .o_drvalid(o_drvalid), .o_drdata(o_drdata),
    .o_mreq(o_mreq), .o_maddr(o_maddr), .o_mwen(o_mwen), .o_mwdata(o_mwdata),
    .o_mmask(o_mmask), .i_mready(i_mready), .i_mrvalid(i_mrvalid), .i_mrdata(i_mrdata)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state: fetch-starvation count, pending losers, last delivered words
  int unsigned starve = 0;
  bit          ireq_hold = 1'b0;
  bit          dreq_hold = 1'b0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rand_fields();
    i_iaddr  = $urandom & 32'hFFFF_FFFC;
    i_daddr  = $urandom & 32'hFFFF_FFFC;
    i_dwen   = 1'($urandom_range(0, 1));
    i_dwdata = $urandom;
    i_dmask  = 4'($urandom_range(0, 15));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_iready"},  32'(o_iready),  32'd0);
    check({tag, "_dready"},  32'(o_dready),  32'd0);
    check({tag, "_irvalid"}, 32'(o_irvalid), 32'd0);
    check({tag, "_drvalid"}, 32'(o_drvalid), 32'd0);
    check({tag, "_irdata"},  o_irdata,       32'd0);
    check({tag, "_drdata"},  o_drdata,       32'd0);
    check({tag, "_mreq"},    32'(o_mreq),    32'd0);
    check({tag, "_maddr"},   o_maddr,        32'd0);
    check({tag, "_mwen"},    32'(o_mwen),    32'd0);
    check({tag, "_mwdata"},  o_mwdata,       32'd0);
    check({tag, "_mmask"},   32'(o_mmask),   32'd0);
  endtask

  // One transaction from an idle cycle; caller has set request fields.
  task automatic run_txn(input bit ir, input bit dr, input int unsigned rdly,
                         input int unsigned vdly, input logic [31:0] rdata,
                         output bit got_f);
    bit          exp_f;
    logic [31:0] e_addr, e_wdata;
    logic        e_wen;
    logic [3:0]  e_mask;
    i_ireq    = ir;
    i_dreq    = dr;
    i_mready  = 1'($urandom_range(0, 1));
    i_mrvalid = 1'($urandom_range(0, 1));
    i_mrdata  = $urandom;
    got_f     = 1'b0;
    if (!ir && !dr) begin
      #4;
      check("idle_iready", 32'(o_iready), 32'd0);
      check("idle_dready", 32'(o_dready), 32'd0);
      next_cycle();
      return;
    end
    exp_f   = ir && (!dr || starve == LIM);
    e_addr  = exp_f ? i_iaddr : i_daddr;
    e_wen   = exp_f ? 1'b0 : i_dwen;
    e_wdata = exp_f ? 32'd0 : i_dwdata;
    e_mask  = exp_f ? 4'hF : i_dmask;
    #4;
    check("grant_iready", 32'(o_iready), 32'(exp_f));
    check("grant_dready", 32'(o_dready), 32'(!exp_f));
    check("grant_mreq",   32'(o_mreq),   32'd0);
    got_f = o_iready;
    if (exp_f) starve = 0;
    else if (ir && starve < LIM) starve++;
    ireq_hold = ir && !exp_f;
    dreq_hold = dr && exp_f;
    next_cycle();

    for (int c = 0; c <= int'(rdly); c++) begin
      rand_fields();
      i_ireq    = ireq_hold | 1'($urandom_range(0, 1));
      i_dreq    = dreq_hold | 1'($urandom_range(0, 1));
      i_mready  = (c == int'(rdly));
      i_mrvalid = 1'($urandom_range(0, 1));
      i_mrdata  = $urandom;
      #4;
      check("req_mreq",   32'(o_mreq),   32'd1);
      check("req_maddr",  o_maddr,       e_addr);
      check("req_mwen",   32'(o_mwen),   32'(e_wen));
      check("req_mwdata", o_mwdata,      e_wdata);
      check("req_mmask",  32'(o_mmask),  32'(e_mask));
      check("req_ready",  32'({o_iready, o_dready}),   32'd0);
      check("req_rvalid", 32'({o_irvalid, o_drvalid}), 32'd0);
      next_cycle();
    end

    for (int c = 0; c <= int'(vdly); c++) begin
      i_mready  = 1'($urandom_range(0, 1));
      i_mrvalid = (c == int'(vdly));
      i_mrdata  = (c == int'(vdly)) ? rdata : $urandom;
      #4;
      check("wait_mreq",  32'(o_mreq), 32'd0);
      check("wait_mbus",  o_maddr | o_mwdata | 32'(o_mmask) | 32'(o_mwen), 32'd0);
      check("wait_ready", 32'({o_iready, o_dready}),   32'd0);
      check("wait_rvalid", 32'({o_irvalid, o_drvalid}), 32'd0);
      next_cycle();
    end

    if (exp_f) last_i = rdata;
    else       last_d = rdata;
    i_mrvalid = 1'($urandom_range(0, 1));
    i_mrdata  = $urandom;
    #4;
    check("resp_irvalid", 32'(o_irvalid), 32'(exp_f));
    check("resp_drvalid", 32'(o_drvalid), 32'(!exp_f));
    check("resp_irdata",  o_irdata, last_i);
    check("resp_drdata",  o_drdata, last_d);
    check("resp_ready",   32'({o_iready, o_dready}), 32'd0);
    check("resp_mreq",    32'(o_mreq), 32'd0);
    next_cycle();
    i_ireq = ireq_hold;
    i_dreq = dreq_hold;
  endtask

  task automatic reset_model();
    starve = 0; ireq_hold = 1'b0; dreq_hold = 1'b0; last_i = '0; last_d = '0;
  endtask

  initial begin
    bit got;
    i_rst = 1'b1; i_ireq = 1'b1; i_dreq = 1'b1; i_mready = 1'b0; i_mrvalid = 1'b1;
    i_mrdata = 32'hFFFF_FFFF;
    rand_fields();
    repeat (2) @(posedge i_clk);
    #5;
    check_zero("rst");
    next_cycle();
    i_rst = 1'b0; i_ireq = 1'b0; i_dreq = 1'b0; i_mrvalid = 1'b0;
    reset_model();

    // Single fetch
    i_iaddr = 32'h100;
    run_txn(1'b1, 1'b0, 0, 0, 32'hDEAD_BEEF, got);
    check("fetch_granted", 32'(got), 32'd1);
    check("fetch_data", o_irdata, 32'hDEAD_BEEF);

    // Data write with memory stalling two cycles
    i_daddr = 32'h200; i_dwen = 1'b1; i_dwdata = 32'h1234_5678; i_dmask = 4'b1100;
    run_txn(1'b0, 1'b1, 2, 0, 32'hA5A5_0001, got);
    check("write_granted_data", 32'(got), 32'd0);

    // Simultaneous: data first, then the waiting fetch
    rand_fields();
    run_txn(1'b1, 1'b1, 0, 1, $urandom, got);
    check("simul_first_data", 32'(got), 32'd0);
    rand_fields();
    run_txn(ireq_hold, 1'b0, 1, 0, $urandom, got);
    check("simul_then_fetch", 32'(got), 32'd1);

    // Starvation: D,D,D,D,I repeating
    for (int i = 0; i < 10; i++) begin
      rand_fields();
      run_txn(1'b1, 1'b1, 0, 0, $urandom, got);
      check("starve_pattern", 32'(got), 32'((i % 5) == 4));
    end

    // Reset while waiting for the memory response
    i_ireq = 1'b0; i_dreq = 1'b1; i_mready = 1'b0; i_mrvalid = 1'b0;
    rand_fields();
    next_cycle();
    i_dreq = 1'b0; i_mready = 1'b1;
    next_cycle();
    i_mready = 1'b0; i_rst = 1'b1;
    next_cycle();
    i_rst = 1'b0;
    reset_model();
    for (int c = 0; c < 3; c++) begin
      i_mrvalid = 1'b1; i_mrdata = $urandom;
      #4;
      check_zero("rst_wait");
      next_cycle();
    end
    i_mrvalid = 1'b0;

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      rand_fields();
      run_txn(ireq_hold | 1'($urandom_range(0, 1)),
              dreq_hold | ($urandom_range(0, 2) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
